pong_match_ctrl: RTL and testbench

Match controller for the Pong datapath. It sits directly downstream of the ball-movement stage and consumes that stage's `collided` and `missed` flags once per frame. From them it maintains the hit score and remaining lives and runs the serve/play/game-over state machine. It also drives `ball_hold`, which parks the ball in its serve position between rallies; the score and lives outputs feed the on-screen overlay.

---
 rtl/pong_pkg.sv | 41 ++++
 rtl/pong_match_ctrl_bcd.sv | 33 +++
 rtl/pong_match_ctrl.sv | 130 +++++++++++++
 tb/tb_pong_match_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM encoding, score width, playfield geometry and
// the saturating two-digit BCD increment used by the score counter.
package pong_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_GAME_OVER = 3'd3
    } state_e;

    localparam int SCORE_W   = 8;
    localparam int LIVES_W   = 3;
    localparam int SERVE_W   = 8;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int BALL_SIZE = 8;
    localparam int BALL_X0   = (H_VISIBLE - BALL_SIZE) / 2;
    localparam int BALL_Y0   = (V_VISIBLE - BALL_SIZE) / 2;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;
    localparam int PADDLE_X  = 16;

    // 99 is the ceiling; otherwise units 9 rolls to 0 and carries into tens.
    function automatic logic [SCORE_W-1:0] bcd2_inc_sat(input logic [SCORE_W-1:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (v == 8'h99)
            return v;
        else if (units >= 4'd9)
            return {4'(tens + 4'd1), 4'd0};
        else
            return {tens, 4'(units + 4'd1)};
    endfunction

endpackage

// File: rtl/pong_match_ctrl_bcd.sv
// Two-digit BCD counter with synchronous clear, increment enable and
// saturation at 99; asynchronously resets to 00.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] value
);

    logic [SCORE_W-1:0] value_q;
    logic [SCORE_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr)
            value_d = '0;
        else if (inc)
            value_d = bcd2_inc_sat(value_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: turns per-frame collide/miss flags into score and
// lives, and sequences IDLE -> SERVE -> PLAY -> GAME_OVER.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               endofframe,
    input  logic               collided,
    input  logic               missed,
    input  logic               start_btn,
    output logic               ball_hold,
    output logic [STATE_W-1:0] state,
    output logic [SCORE_W-1:0] score_bcd,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               frame_tick
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);

    logic               eof_q,        eof_d;
    logic               frame_tick_q, frame_tick_d;
    logic               hit_seen_q,   hit_seen_d;
    logic               miss_seen_q,  miss_seen_d;
    state_e             state_q,      state_d;
    logic [LIVES_W-1:0] lives_q,      lives_d;
    logic [SERVE_W-1:0] serve_cnt_q,  serve_cnt_d;
    logic               ball_hold_q,  ball_hold_d;
    logic               game_over_q,  game_over_d;
    logic               hit_now;
    logic               miss_now;
    logic               score_clr;
    logic               score_inc;

    assign eof_d        = endofframe;
    assign frame_tick_d = endofframe & ~eof_q;

    // The tick cycle sees latch OR live input, so a same-cycle event still counts.
    assign hit_now     = hit_seen_q | collided;
    assign miss_now    = miss_seen_q | missed;
    assign hit_seen_d  = frame_tick_q ? 1'b0 : hit_now;
    assign miss_seen_d = frame_tick_q ? 1'b0 : miss_now;

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        serve_cnt_d = serve_cnt_q;
        score_clr   = 1'b0;
        score_inc   = 1'b0;
        if (frame_tick_q) begin
            case (state_q)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start_btn) begin
                        score_clr   = 1'b1;
                        lives_d     = LIVES_INIT;
                        serve_cnt_d = '0;
                        state_d     = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (serve_cnt_q == SERVE_LAST)
                        state_d = ST_PLAY;
                    else
                        serve_cnt_d = serve_cnt_q + 1'b1;
                end
                ST_PLAY: begin
                    // A miss in the frame wins; any hit in the same frame is dropped.
                    if (miss_now) begin
                        lives_d = lives_q - 1'b1;
                        if (lives_q == 3'd1) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d     = ST_SERVE;
                            serve_cnt_d = '0;
                        end
                    end else if (hit_now) begin
                        score_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        ball_hold_d = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eof_q        <= 1'b0;
            frame_tick_q <= 1'b0;
            hit_seen_q   <= 1'b0;
            miss_seen_q  <= 1'b0;
            state_q      <= ST_IDLE;
            lives_q      <= LIVES_INIT;
            serve_cnt_q  <= '0;
            ball_hold_q  <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            eof_q        <= eof_d;
            frame_tick_q <= frame_tick_d;
            hit_seen_q   <= hit_seen_d;
            miss_seen_q  <= miss_seen_d;
            state_q      <= state_d;
            lives_q      <= lives_d;
            serve_cnt_q  <= serve_cnt_d;
            ball_hold_q  <= ball_hold_d;
            game_over_q  <= game_over_d;
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .value (score_bcd)
    );

    assign ball_hold  = ball_hold_q;
    assign state      = state_q;
    assign lives      = lives_q;
    assign game_over  = game_over_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomised frame-level bench for pong_match_ctrl against a decimal-score
// reference model of the match rules.
module tb_pong_match_ctrl;

    localparam int LIVES_P = 3;
    localparam int SF_P    = 3;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_GO = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       endofframe = 1'b0;
    logic       collided = 1'b0;
    logic       missed = 1'b0;
    logic       start_btn = 1'b0;
    logic       bh;
    logic [2:0] st;
    logic [7:0] sc;
    logic [2:0] lv;
    logic       gov;
    logic       ft;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state, m_score, m_lives, m_serve_left;

    pong_match_ctrl #(.LIVES(LIVES_P), .SERVE_FRAMES(SF_P)) dut (
        .clk        (clk),
        .reset      (reset),
        .endofframe (endofframe),
        .collided   (collided),
        .missed     (missed),
        .start_btn  (start_btn),
        .ball_hold  (bh),
        .state      (st),
        .score_bcd  (sc),
        .lives      (lv),
        .game_over  (gov),
        .frame_tick (ft)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function logic [15:0] exp_vec();
        return {3'(m_state), to_bcd(m_score), 3'(m_lives),
                1'(m_state != M_PLAY), 1'(m_state == M_GO)};
    endfunction

    function logic [15:0] dut_vec();
        return {st, sc, lv, bh, gov};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_score = 0; m_lives = LIVES_P; m_serve_left = 0;
    endtask

    // One frame of match rules applied at its tick.
    task automatic model_tick(input bit hit, input bit miss, input bit start);
        case (m_state)
            M_IDLE, M_GO:
                if (start) begin
                    m_score = 0; m_lives = LIVES_P;
                    m_state = M_SERVE; m_serve_left = SF_P;
                end
            M_SERVE: begin
                m_serve_left--;
                if (m_serve_left == 0) m_state = M_PLAY;
            end
            M_PLAY:
                if (miss) begin
                    m_lives--;
                    if (m_lives == 0) m_state = M_GO;
                    else begin m_state = M_SERVE; m_serve_left = SF_P; end
                end else if (hit) begin
                    if (m_score < 99) m_score++;
                end
            default: ;
        endcase
    endtask

    // Drives one frame (low window with events, then held-high endofframe).
    // 'late' puts a single-cycle event exactly in the tick cycle instead.
    task automatic run_frame(input bit hit, input bit miss, input bit late,
                             input bit start, input int burst, output int ticks);
        int l, h, hs, ms;
        ticks = 0;
        l  = burst + $urandom_range(6, 12);
        h  = $urandom_range(4, 8);
        hs = $urandom_range(1, l - burst - 1);
        ms = $urandom_range(1, l - 3);
        start_btn = start;
        for (int i = 0; i < l; i++) begin
            endofframe = 1'b0;
            collided = hit && !late && i >= hs && i < hs + burst;
            missed   = miss && !late && i >= ms && i < ms + 2;
            @(negedge clk);
            if (ft) ticks++;
        end
        for (int j = 0; j < h; j++) begin
            endofframe = 1'b1;
            collided = hit && late && j == 1;
            missed   = miss && late && j == 1;
            @(negedge clk);
            if (ft) ticks++;
        end
        collided = 1'b0; missed = 1'b0; start_btn = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec() || ft !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h ft=%b, expected %h ft=0", dut_vec(), ft, exp_vec());
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec() || ft !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %h ft=%b, expected %h ft=0", dut_vec(), ft, exp_vec());
        end
    endtask

    task automatic test_start();
        int t;
        for (int f = 0; f < 1 + SF_P; f++) begin
            run_frame(0, 0, 0, f == 0, 1, t);
            model_tick(0, 0, f == 0);
            n_checks++;
            if (dut_vec() !== exp_vec() || t != 1) begin
                n_fail++;
                $display("FAIL start_frame%0d: got %h ticks=%0d, expected %h ticks=1", f, dut_vec(), t, exp_vec());
            end
        end
        n_checks++;
        if ({st, bh, lv, sc} !== {3'd2, 1'b0, 3'd3, 8'h00}) begin
            n_fail++;
            $display("FAIL start_play: got st=%0d hold=%b lives=%0d score=%h, expected 2 0 3 00", st, bh, lv, sc);
        end
    endtask

    task automatic test_hits();
        int t;
        for (int f = 0; f < 13; f++) begin
            run_frame(1, 0, 0, 0, (f == 12) ? 20 : 5, t);
            model_tick(1, 0, 0);
            n_checks++;
            if (dut_vec() !== exp_vec() || t != 1) begin
                n_fail++;
                $display("FAIL hit_frame%0d: got %h ticks=%0d, expected %h ticks=1", f, dut_vec(), t, exp_vec());
            end
            if (f == 11) begin
                n_checks++;
                if (sc !== 8'h12) begin
                    n_fail++;
                    $display("FAIL bcd_carry: got %h, expected 12", sc);
                end
            end
        end
        n_checks++;
        if (sc !== 8'h13) begin
            n_fail++;
            $display("FAIL long_burst: got %h, expected 13", sc);
        end
    endtask

    task automatic test_miss_beats_hit();
        int t;
        run_frame(1, 1, 0, 0, 4, t);
        model_tick(1, 1, 0);
        n_checks++;
        if (dut_vec() !== exp_vec() || {st, lv, bh, sc} !== {3'd1, 3'd2, 1'b1, 8'h13}) begin
            n_fail++;
            $display("FAIL miss_beats_hit: got %h, expected %h (st1 lives2 hold1 score13)", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_game_over();
        int t;
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f <= SF_P; f++) begin
                run_frame(0, f == SF_P, 0, 0, 1, t);
                model_tick(0, f == SF_P, 0);
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL gameover_seq%0d_%0d: got %h, expected %h", k, f, dut_vec(), exp_vec());
                end
            end
        end
        n_checks++;
        if ({st, lv, gov, bh} !== {3'd3, 3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL gameover_state: got st=%0d lives=%0d go=%b hold=%b, expected 3 0 1 1", st, lv, gov, bh);
        end
        run_frame(1, 1, 0, 0, 3, t);
        model_tick(1, 1, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL gameover_frozen: got %h, expected %h", dut_vec(), exp_vec());
        end
        run_frame(0, 0, 0, 1, 1, t);
        model_tick(0, 0, 1);
        n_checks++;
        if ({st, sc, lv, gov} !== {3'd1, 8'h00, 3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL restart: got st=%0d score=%h lives=%0d go=%b, expected 1 00 3 0", st, sc, lv, gov);
        end
    endtask

    task automatic test_saturation();
        int t;
        for (int f = 0; f < SF_P + 100; f++) begin
            run_frame(f >= SF_P, 0, 0, 0, $urandom_range(1, 4), t);
            model_tick(f >= SF_P, 0, 0);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_frame%0d: got %h, expected %h", f, dut_vec(), exp_vec());
            end
            if (f == SF_P + 98 || f == SF_P + 99) begin
                n_checks++;
                if (sc !== 8'h99) begin
                    n_fail++;
                    $display("FAIL saturate%0d: got %h, expected 99", f, sc);
                end
            end
        end
    endtask

    task automatic test_random();
        int t;
        bit h, m, lt, s;
        for (int f = 0; f < 80; f++) begin
            h  = ($urandom % 2) == 0;
            m  = ($urandom % 4) == 0;
            lt = ($urandom % 4) == 0;
            s  = ($urandom % 3) == 0;
            run_frame(h, m, lt, s, $urandom_range(1, 6), t);
            model_tick(h, m, s);
            n_checks++;
            if (dut_vec() !== exp_vec() || t != 1) begin
                n_fail++;
                $display("FAIL random_frame%0d h%0d m%0d late%0d s%0d: got %h ticks=%0d, expected %h ticks=1",
                         f, h, m, lt, s, dut_vec(), t, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int t, ticks;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int f = 0; f < 1 + SF_P + 7; f++) begin
            run_frame(f > SF_P, 0, 0, f == 0, 2, t);
            model_tick(f > SF_P, 0, f == 0);
        end
        n_checks++;
        if ({st, sc} !== {3'd2, 8'h07} || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL prereset_rally: got %h, expected %h (play, score 07)", dut_vec(), exp_vec());
        end
        @(negedge clk);
        #5 reset = 1'b1;
        endofframe = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec() !== exp_vec() || ft !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h ft=%b, expected %h ft=0", dut_vec(), ft, exp_vec());
        end
        @(negedge clk);
        reset = 1'b0;
        ticks = 0;
        @(negedge clk);
        n_checks++;
        if (ft !== 1'b1) begin
            n_fail++;
            $display("FAIL first_cycle_tick: got %b, expected 1", ft);
        end
        if (ft) ticks++;
        repeat (10) begin
            @(negedge clk);
            if (ft) ticks++;
        end
        n_checks++;
        if (ticks != 1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL held_eof: got ticks=%0d %h, expected ticks=1 %h", ticks, dut_vec(), exp_vec());
        end
        endofframe = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_hits();
        test_miss_beats_hit();
        test_game_over();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
